i2s_stream_ctrl: RTL and testbench
==================================

# i2s_stream_ctrl

Stream sequencer in front of the I2S transmitter. It parses a 5-byte stream header from the host byte stream, validates and latches sample rate and bit depth, and selects the MCLK family. It holds the transmitter in reset while clocks settle, forwards exactly the announced number of audio frames into the transmitter's output FIFO, then waits for playback to drain before accepting the next header. It sits between the USB FIFO receive path and the I2S transmit block, in that block's write clock domain.

## Interface
- SETTLE_CYCLES, 1024: cycles `i2s_reset_o` is held after config before streaming; must be ≥1.
- DRAIN_TIMEOUT, 65535: max cycles spent in DRAIN before error.
- clk_i  in  1  system clock; equals the transmitter FIFO write clock.
- reset_n_i  in  1  synchronous, active-low reset.
- in_data_i  in  8  host byte.
- in_valid_i  in  1  host byte valid.
- in_ready_o  out  1  byte accepted when `in_valid_i & in_ready_o`.
- abort_i  in  1  single-cycle abort request.
- wr_output_FIFO_en_o  out  1  FIFO write strobe.
- wr_output_FIFO_data_o  out  8  FIFO write data.
- wr_output_FIFO_full_i  in  1  FIFO full.
- output_streaming_i  in  1  transmitter streaming flag (byte-clock domain, asynchronous here).
- sample_rate_o  out  3  latched rate code.
- bit_depth_o  out  2  latched depth code.
- clk_sel_o  out  1  0 = 44.1 kHz family, 1 = 48 kHz family.
- i2s_reset_o  out  1  active-high reset to the transmitter and its FIFO.
- busy_o  out  1  high outside HUNT.
- done_o  out  1  one-cycle pulse on normal stream completion.
- error_o  out  1  sticky error.
- error_code_o  out  2  1 = bad config, 2 = zero length, 3 = drain timeout.

## Operation
- Header is 5 bytes:
  - B0 = 0xA5 (magic).
  - B1 = {3'b0 reserved, bit_depth[1:0], sample_rate[2:0]}.
  - B2..B4 = frame count, 24-bit little-endian. One frame is one L+R sample pair.
- Rate codes: 0=44.1k, 1=48k, 2=88.2k, 3=96k, 4=176.4k, 5=192k; 6/7 are invalid. `clk_sel = rate[0]`.
- Depth codes: 0=16 (4 B/frame), 1=24 (6), 2=32 (8), 3=DoP (6).
- States:
  - HUNT: consume bytes; non-0xA5 bytes are discarded silently; 0xA5 → CFG.
  - CFG: consume B1. If nonzero reserved bits or rate ≥6: set error code 1, → HUNT (outputs unchanged). Otherwise latch rate, depth and clk_sel; → LEN.
  - LEN: consume 3 bytes into the frame counter. If count = 0: error code 2, → HUNT. Otherwise clear `error_o`, load the settle counter, → SETTLE.
  - SETTLE: `in_ready_o = 0`; count SETTLE_CYCLES; → STREAM.
  - STREAM: forward bytes; on the final byte, → DRAIN.
  - DRAIN: `in_ready_o = 0`. Exit to HUNT with a `done_o` pulse once a synchronized streaming high has been seen (at any time since STREAM entry) and the synchronized streaming is now low. If the timeout counter reaches DRAIN_TIMEOUT first: error code 3, → HUNT.
- Forwarding: `in_ready_o = ~wr_output_FIFO_full_i`; `wr_output_FIFO_en_o = in_valid_i & in_ready_o`; data is passed through combinationally.
- Counting: a byte-in-frame index (3-bit) wraps at frame size, and the 24-bit frames-remaining counter decrements on wrap. The final byte is the one with frames_remaining = 1 and index = size−1.
- `output_streaming_i` passes through a 2-FF synchronizer before use.
- `abort_i` in any state → HUNT next cycle. `i2s_reset_o` rises that cycle, no `done_o`, error unchanged. Abort has priority over a byte handshake in the same cycle; that byte is not written.
- `error_o`/`error_code_o` hold until the next valid header reaches SETTLE, or reset. A new error overwrites the code.

## Timing
- Reset values: state HUNT, `in_ready_o` 1, `wr_output_FIFO_en_o` 0, data 0, `sample_rate_o` 0, `bit_depth_o` 0, `clk_sel_o` 0, `i2s_reset_o` 1, `busy_o` 0, `done_o` 0, `error_o` 0, `error_code_o` 0. All counters and synchronizers are cleared.
- `i2s_reset_o` is 1 in HUNT/CFG/LEN/SETTLE and 0 in STREAM/DRAIN. It is registered: it falls on the first STREAM cycle.
- `sample_rate_o`/`bit_depth_o`/`clk_sel_o` change only on the cycle after B1 is accepted, and only while `i2s_reset_o` = 1.
- In HUNT/CFG/LEN, `in_ready_o` = 1 and each handshake consumes one byte per cycle.
- From B4 accepted to first possible FIFO write: SETTLE_CYCLES + 1 cycles.
- Stream throughput is one byte per cycle when not full. A full FIFO stalls with no byte loss.
- Reset asserted mid-stream: next cycle equals the reset values.

## Test plan
- Header A5 01 02 00 00, depth 16, 2 frames; send 8 bytes; toggle streaming high then low → `clk_sel_o` = 1; exactly 8 FIFO writes, data in order; `done_o` pulses once; `error_o` = 0.
- Garbage 00 FF 13 before header A5 0C 01 00 00 (24-bit @176.4k, 1 frame) → garbage dropped; rate 4, depth 1, `clk_sel_o` = 0; exactly 6 writes.
- Header A5 06 … → error code 1; return to HUNT; following valid header accepted and clears `error_o` at SETTLE.
- Hold `wr_output_FIFO_full_i` = 1 for 5 cycles mid-frame (32-bit) → `in_ready_o` = 0 for those cycles; no writes; total writes = 8 × frames.
- Valid header with streaming held low → error code 3 after DRAIN_TIMEOUT cycles; no `done_o`. A zero frame count gives error code 2.
- `abort_i` on the 3rd payload byte → no write that cycle; `i2s_reset_o` = 1 next cycle; state HUNT; `done_o` never pulses.

Source files
------------

// File: rtl/i2s_stream_ctrl.sv
// Stream sequencer ahead of the I2S transmitter: parses the 5-byte stream
// header, latches the audio format, holds the transmitter in reset while its
// clocks settle, forwards the announced payload into the output FIFO and then
// waits for playback to drain.
module i2s_stream_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       abort_i,
  output logic       wr_output_FIFO_en_o,
  output logic [7:0] wr_output_FIFO_data_o,
  input  logic       wr_output_FIFO_full_i,
  input  logic       output_streaming_i,
  output logic [2:0] sample_rate_o,
  output logic [1:0] bit_depth_o,
  output logic       clk_sel_o,
  output logic       i2s_reset_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [1:0] error_code_o
);

  localparam logic [7:0] Magic      = 8'hA5;
  localparam logic [1:0] ErrBadCfg  = 2'd1;
  localparam logic [1:0] ErrZeroLen = 2'd2;
  localparam logic [1:0] ErrDrain   = 2'd3;

  typedef enum logic [2:0] {StHunt, StCfg, StLen, StSettle, StStream, StDrain} state_e;

  state_e      state_q, state_d;
  logic [1:0]  len_idx_q, len_idx_d;
  logic [23:0] frames_q, frames_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [31:0] settle_q, settle_d;
  logic [31:0] drain_q, drain_d;
  logic        seen_q, seen_d;
  logic        stream_meta_q, stream_sync_q;
  logic [2:0]  rate_q, rate_d;
  logic [1:0]  depth_q, depth_d;
  logic        clk_sel_q, clk_sel_d;
  logic        i2s_rst_q, i2s_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [2:0]  frame_last;
  logic        ready;
  logic        wr_en;
  logic [7:0]  wr_data;

  // Index of the last byte in a frame for the latched depth (DoP packs like 24-bit).
  always_comb begin
    unique case (depth_q)
      2'd0:    frame_last = 3'd3;
      2'd1:    frame_last = 3'd5;
      2'd2:    frame_last = 3'd7;
      default: frame_last = 3'd5;
    endcase
  end

  // Header parsing, payload counting, drain supervision and abort override.
  always_comb begin
    state_d    = state_q;
    len_idx_d  = len_idx_q;
    frames_d   = frames_q;
    byte_idx_d = byte_idx_q;
    settle_d   = settle_q;
    drain_d    = drain_q;
    seen_d     = seen_q;
    rate_d     = rate_q;
    depth_d    = depth_q;
    clk_sel_d  = clk_sel_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    ready      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;

    unique case (state_q)
      StHunt: begin
        if (in_valid_i && in_data_i == Magic) state_d = StCfg;
      end
      StCfg: begin
        if (in_valid_i) begin
          // Reserved bits set or rate code 6/7.
          if (in_data_i[7:5] != 3'b000 || in_data_i[2:1] == 2'b11) begin
            err_d      = 1'b1;
            err_code_d = ErrBadCfg;
            state_d    = StHunt;
          end else begin
            rate_d    = in_data_i[2:0];
            depth_d   = in_data_i[4:3];
            clk_sel_d = in_data_i[0];
            len_idx_d = 2'd0;
            state_d   = StLen;
          end
        end
      end
      StLen: begin
        if (in_valid_i) begin
          len_idx_d = len_idx_q + 2'd1;
          unique case (len_idx_q)
            2'd0: frames_d[7:0]  = in_data_i;
            2'd1: frames_d[15:8] = in_data_i;
            default: begin
              frames_d[23:16] = in_data_i;
              if ({in_data_i, frames_q[15:0]} == 24'd0) begin
                err_d      = 1'b1;
                err_code_d = ErrZeroLen;
                state_d    = StHunt;
              end else begin
                err_d      = 1'b0;
                err_code_d = 2'd0;
                settle_d   = SETTLE_CYCLES - 1;
                state_d    = StSettle;
              end
            end
          endcase
        end
      end
      StSettle: begin
        ready = 1'b0;
        if (settle_q == 32'd0) begin
          byte_idx_d = 3'd0;
          seen_d     = 1'b0;
          state_d    = StStream;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      StStream: begin
        ready   = ~wr_output_FIFO_full_i;
        wr_data = in_data_i;
        if (stream_sync_q) seen_d = 1'b1;
        if (in_valid_i && ready) begin
          wr_en = 1'b1;
          if (byte_idx_q == frame_last) begin
            byte_idx_d = 3'd0;
            frames_d   = frames_q - 24'd1;
            if (frames_q == 24'd1) begin
              drain_d = 32'd0;
              state_d = StDrain;
            end
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      default: begin // StDrain
        ready = 1'b0;
        if (stream_sync_q) seen_d = 1'b1;
        if (seen_q && !stream_sync_q) begin
          done_d  = 1'b1;
          state_d = StHunt;
        end else if (drain_q == DRAIN_TIMEOUT - 1) begin
          err_d      = 1'b1;
          err_code_d = ErrDrain;
          state_d    = StHunt;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
    endcase

    // Abort wins over everything, including a byte offered in the same cycle.
    if (abort_i) begin
      state_d    = StHunt;
      done_d     = 1'b0;
      wr_en      = 1'b0;
      rate_d     = rate_q;
      depth_d    = depth_q;
      clk_sel_d  = clk_sel_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      if (state_q == StStream) ready = 1'b0;
    end

    i2s_rst_d = !(state_d == StStream || state_d == StDrain);
  end

  // State, counters, latched format and the streaming-flag synchronizer.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= StHunt;
      len_idx_q     <= 2'd0;
      frames_q      <= 24'd0;
      byte_idx_q    <= 3'd0;
      settle_q      <= 32'd0;
      drain_q       <= 32'd0;
      seen_q        <= 1'b0;
      stream_meta_q <= 1'b0;
      stream_sync_q <= 1'b0;
      rate_q        <= 3'd0;
      depth_q       <= 2'd0;
      clk_sel_q     <= 1'b0;
      i2s_rst_q     <= 1'b1;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      len_idx_q     <= len_idx_d;
      frames_q      <= frames_d;
      byte_idx_q    <= byte_idx_d;
      settle_q      <= settle_d;
      drain_q       <= drain_d;
      seen_q        <= seen_d;
      stream_meta_q <= output_streaming_i;
      stream_sync_q <= stream_meta_q;
      rate_q        <= rate_d;
      depth_q       <= depth_d;
      clk_sel_q     <= clk_sel_d;
      i2s_rst_q     <= i2s_rst_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign in_ready_o            = ready;
  assign wr_output_FIFO_en_o   = wr_en;
  assign wr_output_FIFO_data_o = wr_data;
  assign sample_rate_o         = rate_q;
  assign bit_depth_o           = depth_q;
  assign clk_sel_o             = clk_sel_q;
  assign i2s_reset_o           = i2s_rst_q;
  assign busy_o                = (state_q != StHunt);
  assign done_o                = done_q;
  assign error_o               = err_q;
  assign error_code_o          = err_code_q;

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Directed bench for i2s_stream_ctrl with short settle/drain parameters.
`timescale 1ns/1ps
module tb_i2s_stream_ctrl;

  localparam int unsigned Settle = 4;
  localparam int unsigned Drain  = 30;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       streaming;
  logic [2:0] rate;
  logic [1:0] depth;
  logic       clk_sel;
  logic       i2s_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] wr_log [0:1023];
  int wr_n   = 0;
  int done_n = 0;

  i2s_stream_ctrl #(
    .SETTLE_CYCLES(Settle),
    .DRAIN_TIMEOUT(Drain)
  ) dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .in_data_i            (in_data),
    .in_valid_i           (in_valid),
    .in_ready_o           (in_ready),
    .abort_i              (abort),
    .wr_output_FIFO_en_o  (wr_en),
    .wr_output_FIFO_data_o(wr_data),
    .wr_output_FIFO_full_i(full),
    .output_streaming_i   (streaming),
    .sample_rate_o        (rate),
    .bit_depth_o          (depth),
    .clk_sel_o            (clk_sel),
    .i2s_reset_o          (i2s_rst),
    .busy_o               (busy),
    .done_o               (done),
    .error_o              (err),
    .error_code_o         (err_code)
  );

  always #5 clk = ~clk;

  // Log FIFO writes and done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wr_en === 1'b1) begin
      wr_log[wr_n] = wr_data;
      wr_n++;
    end
    if (done === 1'b1) done_n++;
  end

  // Offer one byte starting at posedge+1; returns at posedge+1 after it is taken.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      guard++;
    end while (in_ready !== 1'b1 && guard < 200);
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %02h never accepted, ready=%b required 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Pulse the transmitter streaming flag and wait for the sequencer to leave DRAIN.
  task automatic stream_finish();
    int k;
    streaming = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    streaming = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit: busy=%b required 0", busy);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
    full = 1'b0; streaming = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b need 1", in_ready); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b need 0", wr_en); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h need 00", wr_data); end
    n_checks++; if (rate !== 3'd0) begin n_fail++; $display("FAIL rst_rate: got %0d need 0", rate); end
    n_checks++; if (depth !== 2'd0) begin n_fail++; $display("FAIL rst_depth: got %0d need 0", depth); end
    n_checks++; if (clk_sel !== 1'b0) begin n_fail++; $display("FAIL rst_clk_sel: got %b need 0", clk_sel); end
    n_checks++; if (i2s_rst !== 1'b1) begin n_fail++; $display("FAIL rst_i2s_reset: got %b need 1", i2s_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b need 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b need 0", err); end
    n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL rst_code: got %0d need 0", err_code); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int wb, db, k;
    wb = wr_n; db = done_n;
    send_byte(8'hA5);
    send_byte(8'h01);
    n_checks++; if (rate !== 3'd1) begin n_fail++; $display("FAIL basic_rate: got %0d need 1", rate); end
    n_checks++; if (clk_sel !== 1'b1) begin n_fail++; $display("FAIL basic_clk_sel: got %b need 1", clk_sel); end
    n_checks++; if (depth !== 2'd0) begin n_fail++; $display("FAIL basic_depth: got %0d need 0", depth); end
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    // First payload byte offered immediately; it must wait out the settle time.
    in_valid = 1'b1;
    in_data  = 8'h10;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (in_ready !== 1'b1 && k < 50);
    n_checks++; if (k != Settle + 1) begin n_fail++; $display("FAIL settle_latency: got %0d need %0d", k, Settle + 1); end
    n_checks++; if (i2s_rst !== 1'b0) begin n_fail++; $display("FAIL stream_i2s_reset: got %b need 0", i2s_rst); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) send_byte(8'h10 + 8'(i));
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_hold: busy=%b ready=%b need 1 0", busy, in_ready); end
    stream_finish();
    n_checks++; if (wr_n - wb != 8) begin n_fail++; $display("FAIL basic_writes: got %0d need 8", wr_n - wb); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (wr_log[wb + i] !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h need %h", i, wr_log[wb + i], 8'h10 + 8'(i));
      end
    end
    n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses need 1", done_n - db); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b need 0", err); end
    n_checks++; if (i2s_rst !== 1'b1) begin n_fail++; $display("FAIL basic_i2s_reset_end: got %b need 1", i2s_rst); end
  endtask

  task automatic test_garbage();
    int wb, db;
    logic [7:0] hdr [0:7];
    hdr = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h0C, 8'h01, 8'h00, 8'h00};
    wb = wr_n; db = done_n;
    for (int i = 0; i < 8; i++) send_byte(hdr[i]);
    n_checks++; if (rate !== 3'd4) begin n_fail++; $display("FAIL garb_rate: got %0d need 4", rate); end
    n_checks++; if (depth !== 2'd1) begin n_fail++; $display("FAIL garb_depth: got %0d need 1", depth); end
    n_checks++; if (clk_sel !== 1'b0) begin n_fail++; $display("FAIL garb_clk_sel: got %b need 0", clk_sel); end
    for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
    stream_finish();
    n_checks++; if (wr_n - wb != 6) begin n_fail++; $display("FAIL garb_writes: got %0d need 6", wr_n - wb); end
    n_checks++; if (wr_log[wb] !== 8'hC0) begin n_fail++; $display("FAIL garb_first: got %h need C0", wr_log[wb]); end
    n_checks++; if (wr_log[wb + 5] !== 8'hC5) begin n_fail++; $display("FAIL garb_last: got %h need C5", wr_log[wb + 5]); end
    n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL garb_done: got %0d need 1", done_n - db); end
  endtask

  task automatic test_bad_cfg();
    int db;
    db = done_n;
    send_byte(8'hA5);
    send_byte(8'h06);
    n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL badcfg_err: got %b/%0d need 1/1", err, err_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badcfg_hunt: busy=%b need 0", busy); end
    n_checks++; if (rate !== 3'd4 || depth !== 2'd1) begin n_fail++; $display("FAIL badcfg_keep: rate %0d depth %0d need 4 1", rate, depth); end
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL badcfg_hold: got %b need 1", err); end
    send_byte(8'h00);
    n_checks++; if (err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL badcfg_clear: got %b/%0d need 0/0", err, err_code); end
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i));
    stream_finish();
    n_checks++; if (done_n - db != 1) begin n_fail++; $display("FAIL badcfg_done: got %0d need 1", done_n - db); end
  endtask

  task automatic test_full_stall();
    int wb, bad;
    wb = wr_n; bad = 0;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'h80 + 8'(i));
    full     = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h83;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || wr_en !== 1'b0) bad++;
    end
    @(posedge clk);
    #1;
    full = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_blocked: %0d bad cycles need 0", bad); end
    for (int i = 3; i < 16; i++) send_byte(8'h80 + 8'(i));
    stream_finish();
    n_checks++; if (wr_n - wb != 16) begin n_fail++; $display("FAIL stall_writes: got %0d need 16", wr_n - wb); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wr_log[wb + i] !== 8'h80 + 8'(i)) begin
        n_fail++; $display("FAIL stall_data[%0d]: got %h need %h", i, wr_log[wb + i], 8'h80 + 8'(i));
      end
    end
  endtask

  task automatic test_drain_timeout();
    int db, k;
    db = done_n;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (err !== 1'b1 && k < 200);
    n_checks++; if (k < Drain || k > Drain + 2) begin n_fail++; $display("FAIL timeout_time: got %0d cycles need %0d..%0d", k, Drain, Drain + 2); end
    n_checks++; if (err_code !== 2'd3) begin n_fail++; $display("FAIL timeout_code: got %0d need 3", err_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_hunt: busy=%b need 0", busy); end
    n_checks++; if (done_n != db) begin n_fail++; $display("FAIL timeout_done: got %0d pulses need 0", done_n - db); end
    @(posedge clk);
    #1;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    n_checks++; if (err !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL zero_len: got %b/%0d need 1/2", err, err_code); end
    n_checks++; if (busy !== 1'b0 || i2s_rst !== 1'b1) begin n_fail++; $display("FAIL zero_len_hunt: busy %b rst %b need 0 1", busy, i2s_rst); end
  endtask

  task automatic test_abort();
    int wb, db;
    wb = wr_n; db = done_n;
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h31);
    in_valid = 1'b1;
    in_data  = 8'h32;
    abort    = 1'b1;
    @(negedge clk);
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_no_write: got %b need 0", wr_en); end
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (i2s_rst !== 1'b1) begin n_fail++; $display("FAIL abort_i2s_reset: got %b need 1", i2s_rst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_hunt: busy=%b need 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_error: got %b need 0", err); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (wr_n - wb != 2) begin n_fail++; $display("FAIL abort_writes: got %0d need 2", wr_n - wb); end
    n_checks++; if (done_n != db) begin n_fail++; $display("FAIL abort_done: got %0d pulses need 0", done_n - db); end
  endtask

  task automatic test_mid_reset();
    send_byte(8'hA5);
    send_byte(8'h0D);
    n_checks++; if (rate !== 3'd5 || depth !== 2'd1 || clk_sel !== 1'b1) begin n_fail++; $display("FAIL mid_cfg: rate %0d depth %0d sel %b need 5 1 1", rate, depth, clk_sel); end
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || i2s_rst !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ctl: busy %b rst %b ready %b need 0 1 1", busy, i2s_rst, in_ready); end
    n_checks++; if (rate !== 3'd0 || depth !== 2'd0 || clk_sel !== 1'b0) begin n_fail++; $display("FAIL mid_reset_cfg: rate %0d depth %0d sel %b need 0 0 0", rate, depth, clk_sel); end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_bad_cfg();
    test_full_stall();
    test_drain_timeout();
    test_abort();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
